// File: rtl/sdram_line_reader.sv
// Avalon-MM burst-less line reader: streams word_count SDRAM words into a show-ahead FIFO.
// Optional underrun counter port enabled by defining SDRAM_READER_UNDERRUN_CNT_EN.
module sdram_line_reader #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic        start,
  input  logic [24:0] base_addr,
  input  logic [15:0] word_count,
  output logic        busy,
  output logic        done,
  output logic [24:0] sdram_address,
  output logic        sdram_chipselect,
  output logic        sdram_read_n,
  output logic        sdram_write_n,
  output logic [1:0]  sdram_byteenable_n,
  output logic [15:0] sdram_writedata,
  input  logic [15:0] sdram_readdata,
  input  logic        sdram_readdatavalid,
  input  logic        sdram_waitrequest,
  output logic [15:0] pix_data,
  output logic        pix_valid,
  input  logic        pix_ready
`ifdef SDRAM_READER_UNDERRUN_CNT_EN
  ,
  output logic [15:0] underrun_count
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;

  state_t state, state_nx;

  logic          rd_req, rd_req_nx;
  logic [24:0]   addr;
  logic [15:0]   remaining;
  logic [CW-1:0] outstanding, outstanding_nx;
  logic [CW-1:0] fifo_count, fifo_count_nx;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [15:0]   mem [FIFO_DEPTH];
  logic          start_ok, accept, last_accept;
  logic          push, pop, room;

  assign start_ok    = (state == IDLE) && start;
  assign accept      = rd_req && !sdram_waitrequest;
  assign last_accept = accept && (remaining == 16'd1);
  // Responses with nothing in flight (e.g. after a reset) are discarded.
  assign push = sdram_readdatavalid && (state != IDLE)
             && (outstanding != '0);
  assign pop  = pix_valid && pix_ready;

  always_comb begin
    outstanding_nx = outstanding;
    if (accept && !push)
      outstanding_nx = outstanding + CW'(1);
    else if (!accept && push)
      outstanding_nx = outstanding - CW'(1);
  end

  always_comb begin
    fifo_count_nx = fifo_count;
    if (push && !pop)
      fifo_count_nx = fifo_count + CW'(1);
    else if (!push && pop)
      fifo_count_nx = fifo_count - CW'(1);
  end

  // Credit looks at next-cycle counts so a registered read_n never overfills.
  assign room = ({1'b0, outstanding_nx} + {1'b0, fifo_count_nx})
              < (CW+1)'(FIFO_DEPTH);

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) state <= IDLE;
    else             state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    rd_req_nx = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx  = (word_count != 16'd0) ? ISSUE : DRAIN;
          rd_req_nx = (word_count != 16'd0);
        end
      end
      ISSUE: begin
        if (rd_req && sdram_waitrequest) begin
          rd_req_nx = 1'b1;
        end else begin
          rd_req_nx = !last_accept && room;
        end
        if (last_accept) state_nx = DRAIN;
      end
      DRAIN: begin
        if (outstanding == '0 && fifo_count == '0)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      rd_req      <= 1'b0;
      addr        <= '0;
      remaining   <= '0;
      outstanding <= '0;
      fifo_count  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      rd_req      <= rd_req_nx;
      outstanding <= outstanding_nx;
      fifo_count  <= fifo_count_nx;
      if (start_ok) begin
        addr      <= base_addr;
        remaining <= word_count;
      end else if (accept) begin
        addr      <= addr + 25'd1;
        remaining <= remaining - 16'd1;
      end
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
    end
  end

  always_ff @(posedge clk_clk) begin
    if (push) mem[wr_ptr] <= sdram_readdata;
  end

  assign pix_valid = (fifo_count != '0);
  assign pix_data  = pix_valid ? mem[rd_ptr] : 16'd0;

  assign busy = (state != IDLE);
  assign done = (state == DRAIN) && (outstanding == '0)
             && (fifo_count == '0);

  assign sdram_address      = addr;
  assign sdram_chipselect   = rd_req;
  assign sdram_read_n       = !rd_req;
  assign sdram_write_n      = 1'b1;
  assign sdram_byteenable_n = 2'b00;
  assign sdram_writedata    = 16'd0;

`ifdef SDRAM_READER_UNDERRUN_CNT_EN
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset)
      underrun_count <= '0;
    else if (start_ok)
      underrun_count <= '0;
    else if (busy && pix_ready && !pix_valid
             && underrun_count != 16'hFFFF)
      underrun_count <= underrun_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_sdram_line_reader.sv
// Directed bench for sdram_line_reader with a small Avalon slave model.
`timescale 1ns/1ps
module tb_sdram_line_reader;

  logic        clk_clk = 1'b0;
  logic        reset_reset = 1'b1;
  logic        start = 1'b0;
  logic [24:0] base_addr = '0;
  logic [15:0] word_count = '0;
  logic        busy, done;
  logic [24:0] sdram_address;
  logic        sdram_chipselect, sdram_read_n, sdram_write_n;
  logic [1:0]  sdram_byteenable_n;
  logic [15:0] sdram_writedata;
  logic [15:0] sdram_readdata = '0;
  logic        sdram_readdatavalid = 1'b0;
  logic        sdram_waitrequest = 1'b0;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic        pix_ready = 1'b1;
`ifdef SDRAM_READER_UNDERRUN_CNT_EN
  logic [15:0] underrun_count;
`endif

  sdram_line_reader #(.FIFO_DEPTH(16)) dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset),
    .start(start), .base_addr(base_addr),
    .word_count(word_count), .busy(busy), .done(done),
    .sdram_address(sdram_address),
    .sdram_chipselect(sdram_chipselect),
    .sdram_read_n(sdram_read_n),
    .sdram_write_n(sdram_write_n),
    .sdram_byteenable_n(sdram_byteenable_n),
    .sdram_writedata(sdram_writedata),
    .sdram_readdata(sdram_readdata),
    .sdram_readdatavalid(sdram_readdatavalid),
    .sdram_waitrequest(sdram_waitrequest),
    .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_ready(pix_ready)
`ifdef SDRAM_READER_UNDERRUN_CNT_EN
    , .underrun_count(underrun_count)
`endif
  );

  always #5 clk_clk = ~clk_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk_clk) cyc <= cyc + 1;

  int lat = 2;
  int wait_idx = -1;
  int wait_left = 0;
  int wait_seen = 0;
  int hold_viol = 0;
  bit stray_req = 0;
  int done_cnt = 0;
  int first_rd_cyc = -1;
  int nacc = 0;
  int start_cyc = 0;
  bit prev_wait = 0;
  logic [24:0] prev_addr = '0;
  logic [24:0] acc_addr[$];
  logic [15:0] pix_log[$];
  int due_q[$];
  logic [15:0] dat_q[$];

  function automatic logic [15:0] dat(input logic [24:0] a);
    return a[15:0] ^ {7'd0, a[24:16]} ^ 16'h5A3C;
  endfunction

  // Slave model and observers, all at the falling edge.
  initial forever begin
    @(negedge clk_clk);
    if (reset_reset) begin
      due_q.delete();
      dat_q.delete();
      sdram_readdatavalid = 0;
      sdram_waitrequest = 0;
      prev_wait = 0;
    end else begin
      if (prev_wait && (sdram_address !== prev_addr
          || sdram_read_n !== 1'b0
          || sdram_chipselect !== 1'b1))
        hold_viol++;
      sdram_readdatavalid = 0;
      sdram_readdata = '0;
      if (stray_req) begin
        sdram_readdatavalid = 1;
        sdram_readdata = 16'hDEAD;
        stray_req = 0;
      end else if (due_q.size() > 0 && due_q[0] == cyc) begin
        sdram_readdatavalid = 1;
        sdram_readdata = dat_q[0];
        void'(due_q.pop_front());
        void'(dat_q.pop_front());
      end
      sdram_waitrequest = 0;
      if (sdram_chipselect && !sdram_read_n) begin
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
        if (nacc == wait_idx && wait_left > 0) begin
          sdram_waitrequest = 1;
          wait_left--;
          wait_seen++;
        end else begin
          acc_addr.push_back(sdram_address);
          due_q.push_back(cyc + lat);
          dat_q.push_back(dat(sdram_address));
          nacc++;
        end
      end
      prev_wait = sdram_waitrequest;
      prev_addr = sdram_address;
      if (pix_valid && pix_ready) pix_log.push_back(pix_data);
      if (done) done_cnt++;
    end
  end

  task automatic clear_logs();
    acc_addr.delete();
    pix_log.delete();
    done_cnt = 0;
    first_rd_cyc = -1;
    nacc = 0;
    wait_idx = -1;
    wait_left = 0;
    wait_seen = 0;
    hold_viol = 0;
  endtask

  task automatic do_start(input logic [24:0] b,
                          input logic [15:0] n);
    @(posedge clk_clk); #1;
    base_addr = b;
    word_count = n;
    start = 1;
    start_cyc = cyc;
    @(posedge clk_clk); #1;
    start = 0;
  endtask

  task automatic wait_idle(input int budget, output bit to);
    int n = 0;
    to = 0;
    while (busy !== 1'b0) begin
      @(negedge clk_clk);
      n++;
      if (n > budget) begin
        to = 1;
        break;
      end
    end
    @(negedge clk_clk);
  endtask

  task automatic test_reset();
    reset_reset = 1;
    repeat (3) @(negedge clk_clk);
    checks++; if (sdram_read_n !== 1'b1) begin errors++; $display("FAIL rst_read_n got %b exp 1", sdram_read_n); end
    checks++; if (sdram_chipselect !== 1'b0) begin errors++; $display("FAIL rst_cs got %b exp 0", sdram_chipselect); end
    checks++; if (sdram_address !== 25'h0) begin errors++; $display("FAIL rst_addr got %h exp 0", sdram_address); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rst_busy_done got %b%b exp 00", busy, done); end
    checks++; if (pix_valid !== 1'b0 || pix_data !== 16'h0) begin errors++; $display("FAIL rst_pix got %b/%h exp 0/0", pix_valid, pix_data); end
    checks++; if (sdram_write_n !== 1'b1 || sdram_byteenable_n !== 2'b00 || sdram_writedata !== 16'h0) begin errors++; $display("FAIL const_out got %b/%b/%h exp 1/00/0000", sdram_write_n, sdram_byteenable_n, sdram_writedata); end
    @(posedge clk_clk); #1;
    reset_reset = 0;
  endtask

  task automatic test_zero_wait();
    bit to;
    logic [24:0] e;
    clear_logs();
    lat = 2;
    pix_ready = 1;
    do_start(25'h100, 16'd8);
    wait_idle(300, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL zw_timeout got %b exp 0", to); end
    checks++; if (first_rd_cyc !== start_cyc + 1) begin errors++; $display("FAIL zw_latency got %0d exp %0d", first_rd_cyc, start_cyc + 1); end
    checks++; if (acc_addr.size() !== 8) begin errors++; $display("FAIL zw_nreads got %0d exp 8", acc_addr.size()); end
    checks++; if (pix_log.size() !== 8) begin errors++; $display("FAIL zw_nwords got %0d exp 8", pix_log.size()); end
    for (int i = 0; i < 8; i++) begin
      e = 25'h100 + 25'(i);
      checks++; if (acc_addr[i] !== e) begin errors++; $display("FAIL zw_addr%0d got %h exp %h", i, acc_addr[i], e); end
      checks++; if (pix_log[i] !== dat(e)) begin errors++; $display("FAIL zw_data%0d got %h exp %h", i, pix_log[i], dat(e)); end
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL zw_done got %0d exp 1", done_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zw_busy got %b exp 0", busy); end
  endtask

  task automatic test_backpressure();
    bit to;
    logic [24:0] e;
    clear_logs();
    @(posedge clk_clk); #1;
    pix_ready = 0;
    do_start(25'h4000, 16'd40);
    repeat (60) @(negedge clk_clk);
    checks++; if (nacc !== 16) begin errors++; $display("FAIL bp_stall_reads got %0d exp 16", nacc); end
    checks++; if (sdram_read_n !== 1'b1) begin errors++; $display("FAIL bp_stall_read_n got %b exp 1", sdram_read_n); end
    checks++; if (pix_valid !== 1'b1) begin errors++; $display("FAIL bp_pix_valid got %b exp 1", pix_valid); end
    @(posedge clk_clk); #1;
    pix_ready = 1;
    wait_idle(2000, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL bp_timeout got %b exp 0", to); end
    checks++; if (pix_log.size() !== 40 || acc_addr.size() !== 40) begin errors++; $display("FAIL bp_count got %0d/%0d exp 40/40", pix_log.size(), acc_addr.size()); end
    for (int i = 0; i < 40; i++) begin
      e = 25'h4000 + 25'(i);
      checks++; if (acc_addr[i] !== e || pix_log[i] !== dat(e)) begin errors++; $display("FAIL bp_word%0d got %h/%h exp %h/%h", i, acc_addr[i], pix_log[i], e, dat(e)); end
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL bp_done got %0d exp 1", done_cnt); end
  endtask

  task automatic test_waitrequest();
    bit to;
    logic [24:0] e;
    clear_logs();
    wait_idx = 2;
    wait_left = 5;
    do_start(25'h2000, 16'd6);
    wait_idle(300, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL wr_timeout got %b exp 0", to); end
    checks++; if (wait_seen !== 5) begin errors++; $display("FAIL wr_stalls got %0d exp 5", wait_seen); end
    checks++; if (hold_viol !== 0) begin errors++; $display("FAIL wr_hold got %0d exp 0", hold_viol); end
    checks++; if (acc_addr.size() !== 6) begin errors++; $display("FAIL wr_nreads got %0d exp 6", acc_addr.size()); end
    for (int i = 0; i < 6; i++) begin
      e = 25'h2000 + 25'(i);
      checks++; if (acc_addr[i] !== e || pix_log[i] !== dat(e)) begin errors++; $display("FAIL wr_word%0d got %h/%h exp %h/%h", i, acc_addr[i], pix_log[i], e, dat(e)); end
    end
  endtask

  task automatic test_wrap();
    bit to;
    logic [24:0] ew [4];
    ew = '{25'h1FFFFFE, 25'h1FFFFFF, 25'h0000000, 25'h0000001};
    clear_logs();
    do_start(25'h1FFFFFE, 16'd4);
    wait_idle(200, to);
    checks++; if (to !== 1'b0 || acc_addr.size() !== 4) begin errors++; $display("FAIL wrap_count got %0d to=%b exp 4 to=0", acc_addr.size(), to); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (acc_addr[i] !== ew[i] || pix_log[i] !== dat(ew[i])) begin errors++; $display("FAIL wrap_word%0d got %h/%h exp %h/%h", i, acc_addr[i], pix_log[i], ew[i], dat(ew[i])); end
    end
  endtask

  task automatic test_zero_count();
    bit to;
    clear_logs();
    do_start(25'h555, 16'd0);
    wait_idle(20, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL zc_timeout got %b exp 0", to); end
    checks++; if (first_rd_cyc !== -1 || nacc !== 0) begin errors++; $display("FAIL zc_reads got %0d exp 0", nacc); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL zc_done got %0d exp 1", done_cnt); end
  endtask

  task automatic test_stray();
    bit to;
    clear_logs();
    stray_req = 1;
    repeat (3) @(negedge clk_clk);
    checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL stray_pix got %b exp 0", pix_valid); end
    do_start(25'h10, 16'd3);
    wait_idle(200, to);
    checks++; if (to !== 1'b0 || pix_log.size() !== 3) begin errors++; $display("FAIL stray_after got %0d to=%b exp 3 to=0", pix_log.size(), to); end
    checks++; if (pix_log[0] !== dat(25'h10)) begin errors++; $display("FAIL stray_data got %h exp %h", pix_log[0], dat(25'h10)); end
  endtask

  task automatic test_busy_ignore();
    bit to;
    clear_logs();
    do_start(25'h300, 16'd8);
    @(posedge clk_clk); #1;
    base_addr = 25'h900;
    word_count = 16'd3;
    start = 1;
    @(posedge clk_clk); #1;
    start = 0;
    wait_idle(300, to);
    checks++; if (to !== 1'b0 || acc_addr.size() !== 8) begin errors++; $display("FAIL bi_count got %0d to=%b exp 8 to=0", acc_addr.size(), to); end
    checks++; if (acc_addr[7] !== 25'h307) begin errors++; $display("FAIL bi_last got %h exp 0000307", acc_addr[7]); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL bi_done got %0d exp 1", done_cnt); end
  endtask

  task automatic test_reset_mid();
    bit to;
    int n = 0;
    logic [24:0] e;
    clear_logs();
    do_start(25'h700, 16'd10);
    while (nacc < 3 && n < 50) begin
      @(negedge clk_clk);
      n++;
    end
    checks++; if (nacc < 3) begin errors++; $display("FAIL rm_reach got %0d exp 3", nacc); end
    @(posedge clk_clk); #1;
    reset_reset = 1;
    #1;
    checks++; if (sdram_read_n !== 1'b1 || sdram_chipselect !== 1'b0) begin errors++; $display("FAIL rm_req got %b/%b exp 1/0", sdram_read_n, sdram_chipselect); end
    checks++; if (sdram_address !== 25'h0) begin errors++; $display("FAIL rm_addr got %h exp 0", sdram_address); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rm_busy_done got %b%b exp 00", busy, done); end
    checks++; if (pix_valid !== 1'b0 || pix_data !== 16'h0) begin errors++; $display("FAIL rm_pix got %b/%h exp 0/0", pix_valid, pix_data); end
    repeat (3) @(posedge clk_clk);
    #1;
    reset_reset = 0;
    repeat (5) @(negedge clk_clk);
    checks++; if (done_cnt !== 0) begin errors++; $display("FAIL rm_no_done got %0d exp 0", done_cnt); end
    clear_logs();
    do_start(25'h40, 16'd4);
    wait_idle(200, to);
    checks++; if (to !== 1'b0 || acc_addr.size() !== 4 || done_cnt !== 1) begin errors++; $display("FAIL rm_restart got %0d reads %0d done exp 4/1", acc_addr.size(), done_cnt); end
    for (int i = 0; i < 4; i++) begin
      e = 25'h40 + 25'(i);
      checks++; if (acc_addr[i] !== e || pix_log[i] !== dat(e)) begin errors++; $display("FAIL rm_word%0d got %h/%h exp %h/%h", i, acc_addr[i], pix_log[i], e, dat(e)); end
    end
  endtask

`ifdef SDRAM_READER_UNDERRUN_CNT_EN
  task automatic test_underrun();
    bit to;
    clear_logs();
    lat = 6;
    pix_ready = 1;
    do_start(25'h80, 16'd4);
    wait_idle(200, to);
    checks++; if (to !== 1'b0 || underrun_count == 16'd0) begin errors++; $display("FAIL ur_count got %0d to=%b exp >0", underrun_count, to); end
    do_start(25'h90, 16'd2);
    checks++; if (underrun_count !== 16'd0) begin errors++; $display("FAIL ur_clear got %0d exp 0", underrun_count); end
    wait_idle(200, to);
    lat = 2;
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog got no finish exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_zero_wait();
    test_backpressure();
    test_waitrequest();
    test_wrap();
    test_zero_count();
    test_stray();
    test_busy_ignore();
    test_reset_mid();
`ifdef SDRAM_READER_UNDERRUN_CNT_EN
    test_underrun();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
